// File: rtl/idle_gate_pkg.sv
// idle_gate_pkg: shared state encoding, idle modes and sizing helper for the idle gate controller
package idle_gate_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    ACTIVE = 3'd0,
    COUNT  = 3'd1,
    DRAIN  = 3'd2,
    SLEEP  = 3'd3,
    WAKE   = 3'd4
  } state_t;
  localparam logic [1:0] MODE_NEVER = 2'b00;
  localparam logic [1:0] MODE_TIMED = 2'b01;
  localparam logic [1:0] MODE_IMMED = 2'b10;
  localparam logic [1:0] MODE_CMD   = 2'b11;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/idle_gate_ctrl_if.sv
// idle_gate_ctrl_if: activity/command inputs and gating status outputs of the idle gate controller
interface idle_gate_ctrl_if #(
  parameter int N_REQ = 7,
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);
  logic                              en;
  logic [N_REQ-1:0]                  req;
  logic [1:0]                        mode;
  logic                              sleep_cmd;
  logic                              force_wake;
  logic [N_CH-1:0]                   gate_en;
  logic                              sleeping;
  logic                              wake_ack;
  logic [idle_gate_pkg::STATE_W-1:0] state_o;
  logic [CNT_W-1:0]                  sleep_cnt;
  modport master (
    output en, req, mode, sleep_cmd, force_wake,
    input  gate_en, sleeping, wake_ack, state_o, sleep_cnt
  );
  modport slave (
    input  en, req, mode, sleep_cmd, force_wake,
    output gate_en, sleeping, wake_ack, state_o, sleep_cnt
  );
endinterface

// File: rtl/idle_gate_timer.sv
// idle_gate_timer: loadable up-counter with clear, increment and terminal compare
module idle_gate_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic         inc,
  input  logic [W-1:0] ld_val,
  input  logic [W-1:0] term,
  output logic         hit
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : ld ? ld_val : inc ? cnt + 1'b1 : cnt;
  assign hit = cnt == term;
endmodule

// File: rtl/idle_gate_ctrl.sv
// idle_gate_ctrl: activity monitor sequencing ACTIVE->COUNT->DRAIN->SLEEP->WAKE and driving channel gates
module idle_gate_ctrl
  import idle_gate_pkg::*;
#(
  parameter int              N_REQ     = 7,
  parameter int              N_CH      = 4,
  parameter int              IDLE_CYC  = 16,
  parameter int              DRAIN_CYC = 4,
  parameter int              WAKE_CYC  = 8,
  parameter logic [N_CH-1:0] ALWAYS_ON = '0,
  parameter int              CNT_W     = 8
) (
  input logic             clk,
  input logic             rst,
  idle_gate_ctrl_if.slave bus
);
  localparam int TW = $clog2(max3(IDLE_CYC, DRAIN_CYC, WAKE_CYC) + 1);
  state_t          state, nxt;
  logic [TW-1:0]   term;
  logic            idle, hit, t_clr, t_ld, t_inc;
  logic [N_CH-1:0] gate_en;
  logic            sleeping, wake_ack;
  logic [CNT_W-1:0] cnt;
  assign idle = bus.en & ~|bus.req;
  always_comb begin
    nxt = ACTIVE;
    case (state)
      ACTIVE: nxt = (bus.force_wake || !idle || bus.mode == MODE_NEVER) ? ACTIVE :
                    (bus.mode == MODE_TIMED) ? ((IDLE_CYC == 1) ? DRAIN : COUNT) :
                    (bus.mode == MODE_IMMED || (bus.mode == MODE_CMD && bus.sleep_cmd)) ? DRAIN : ACTIVE;
      COUNT:  nxt = (!idle || bus.force_wake || bus.mode != MODE_TIMED) ? ACTIVE : hit ? DRAIN : COUNT;
      DRAIN:  nxt = (!idle || bus.force_wake) ? ACTIVE : hit ? SLEEP : DRAIN;
      SLEEP:  nxt = (|bus.req || bus.force_wake || !bus.en) ? WAKE : SLEEP;
      WAKE:   nxt = hit ? ACTIVE : WAKE;
      default: nxt = ACTIVE;
    endcase
  end
  // One timer serves every timed phase; COUNT starts at 1 since the ACTIVE cycle already counted.
  assign term  = (state == COUNT) ? TW'(IDLE_CYC - 1) : (state == DRAIN) ? TW'(DRAIN_CYC - 1) : TW'(WAKE_CYC - 1);
  assign t_inc = nxt == state && (state == COUNT || state == DRAIN || state == WAKE);
  assign t_ld  = state == ACTIVE && nxt == COUNT;
  assign t_clr = !(t_inc || t_ld);
  idle_gate_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (t_clr),
    .ld     (t_ld),
    .inc    (t_inc),
    .ld_val (TW'(1)),
    .term   (term),
    .hit    (hit)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACTIVE;
      gate_en  <= '1;
      sleeping <= 1'b0;
      wake_ack <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= nxt;
      gate_en  <= (nxt == SLEEP) ? ALWAYS_ON : '1;
      sleeping <= nxt == SLEEP;
      wake_ack <= state == WAKE && nxt == ACTIVE;
      if (state == DRAIN && nxt == SLEEP && !(&cnt))
        cnt <= cnt + 1'b1;
    end
  end
  assign bus.state_o   = state;
  assign bus.gate_en   = gate_en;
  assign bus.sleeping  = sleeping;
  assign bus.wake_ack  = wake_ack;
  assign bus.sleep_cnt = cnt;
endmodule

// File: tb/tb_idle_gate_ctrl.sv
// tb_idle_gate_ctrl: scoreboard bench comparing the controller against a phase/duration reference model
module tb_idle_gate_ctrl;
  localparam int        IC  = 16;
  localparam int        DC  = 4;
  localparam int        WC  = 8;
  localparam logic [3:0] AON = 4'b0010;
  typedef struct packed {
    logic [2:0] st;
    logic [3:0] ge;
    logic       sl;
    logic       ack;
    logic [1:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  int   ph = 0;
  int   n = 0;
  int   sc_cnt = 0;
  idle_gate_ctrl_if #(.N_REQ(7), .N_CH(4), .CNT_W(2)) bus ();
  idle_gate_ctrl #(
    .N_REQ(7), .N_CH(4), .IDLE_CYC(IC), .DRAIN_CYC(DC), .WAKE_CYC(WC),
    .ALWAYS_ON(AON), .CNT_W(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  // Phases: 0 active, 1 counting idle, 2 draining, 3 asleep, 4 waking; n counts progress within a phase.
  task automatic cyc(input logic r, input logic e, input logic [6:0] rq, input logic [1:0] m,
                     input logic sc, input logic fw);
    logic idle, ack;
    exp_t x;
    @(negedge clk);
    rst = r; bus.en = e; bus.req = rq; bus.mode = m; bus.sleep_cmd = sc; bus.force_wake = fw;
    idle = e && rq == 7'd0;
    ack = 1'b0;
    if (r) begin
      ph = 0; n = 0; sc_cnt = 0;
    end else if (ph == 0) begin
      if (!fw && idle && m == 2'b01) begin ph = 1; n = 1; end
      else if (!fw && idle && (m == 2'b10 || (m == 2'b11 && sc))) begin ph = 2; n = 0; end
    end else if (ph == 1) begin
      if (!idle || fw || m != 2'b01) ph = 0;
      else begin
        n++;
        if (n == IC) begin ph = 2; n = 0; end
      end
    end else if (ph == 2) begin
      if (!idle || fw) ph = 0;
      else begin
        n++;
        if (n == DC) begin ph = 3; if (sc_cnt < 3) sc_cnt++; end
      end
    end else if (ph == 3) begin
      if (rq != 7'd0 || fw || !e) begin ph = 4; n = 0; end
    end else begin
      n++;
      if (n == WC) begin ph = 0; ack = 1'b1; end
    end
    x.st = 3'(ph);
    x.ge = (ph == 3) ? AON : 4'b1111;
    x.sl = ph == 3;
    x.ack = ack;
    x.cnt = 2'(sc_cnt);
    q.push_back(x);
  endtask
  task automatic run(input int k, input logic r, input logic e, input logic [6:0] rq,
                     input logic [1:0] m, input logic sc, input logic fw);
    for (int i = 0; i < k; i++) cyc(r, e, rq, m, sc, fw);
  endtask
  initial forever begin
    exp_t e, g;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = {bus.state_o, bus.gate_en, bus.sleeping, bus.wake_ack, bus.sleep_cnt};
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL outputs t=%0t st/ge/sl/ack/cnt got %0d/%b/%b/%b/%0d exp %0d/%b/%b/%b/%0d",
                 $time, g.st, g.ge, g.sl, g.ack, g.cnt, e.st, e.ge, e.sl, e.ack, e.cnt);
      end
    end
  end
  initial begin
    logic [1:0] m;
    logic [6:0] rq;
    bus.en = 1'b0; bus.req = '0; bus.mode = 2'b00; bus.sleep_cmd = 1'b0; bus.force_wake = 1'b0;
    run(2, 1, 1, 0, 2'b00, 0, 0);
    run(24, 0, 1, 0, 2'b01, 0, 0);
    run(1, 0, 1, 7'h01, 2'b00, 0, 0);
    run(10, 0, 1, 0, 2'b00, 0, 0);
    run(9, 0, 1, 0, 2'b01, 0, 0);
    run(1, 0, 1, 7'h08, 2'b01, 0, 0);
    run(15, 0, 1, 0, 2'b01, 0, 0);
    run(6, 0, 1, 0, 2'b01, 0, 0);
    run(1, 0, 1, 0, 2'b01, 0, 1);
    run(10, 0, 1, 0, 2'b00, 0, 0);
    run(5, 0, 1, 0, 2'b10, 0, 1);
    run(5, 0, 1, 0, 2'b11, 0, 0);
    run(6, 0, 1, 0, 2'b11, 1, 0);
    for (int k = 0; k < 4; k++) begin
      run(1, 0, 1, 7'h01, 2'b10, 0, 0);
      run(8, 0, 1, 0, 2'b10, 0, 0);
      run(6, 0, 1, 0, 2'b10, 0, 0);
    end
    run(1, 0, 1, 7'h01, 2'b00, 0, 0);
    run(3, 0, 1, 0, 2'b00, 0, 0);
    run(1, 1, 1, 0, 2'b00, 0, 0);
    run(10, 0, 1, 0, 2'b00, 0, 0);
    m = 2'b01;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(63) == 0) m = 2'($urandom_range(3));
      rq = ($urandom_range(29) == 0) ? 7'($urandom_range(127, 1)) : 7'd0;
      cyc($urandom_range(499) == 0, $urandom_range(49) != 0, rq, m,
          $urandom_range(3) == 0, $urandom_range(59) == 0);
    end
    @(negedge clk);
    repeat (2) @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain scoreboard left %0d expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
